lcd_rx_sequencer: RTL and testbench
===================================

# lcd_rx_sequencer

Frame parser and write scheduler between the UART receiver and the LCD write engine. It consumes single-cycle byte strobes from the receiver and decodes 3-byte frames: sync, type, payload, plus an optional checksum byte. Each valid frame becomes one LCD command or data write, buffered in a small FIFO and released over a valid/ready handshake. Malformed, stalled and overflowing frames are dropped and counted.

## Interface
- `FREQ`, 24_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, UART line rate; sets the inter-byte timeout.
- `FIFO_DEPTH`, 4, number of buffered LCD writes; must be a power of two, ≥2.
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is a new received byte.
- `rx_byte`  in  8  received byte; sampled only when `rx_valid`=1.
- `lcd_valid`  out  1  FIFO head is available.
- `lcd_ready`  in  1  LCD engine accepts the head this cycle.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_data`  out  8  byte to write.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `frame_err`  out  1  one-cycle pulse on bad type, bad checksum or timeout.
- `overflow`  out  1  one-cycle pulse when a valid frame is dropped because the FIFO is full.
- `err_count`  out  8  saturating count of `frame_err` and `overflow` events.

## Operation
- Parser states:
  - HUNT: a byte equal to `SYNC_BYTE` moves to TYPE; any other byte is ignored without error.
  - TYPE: 8'h00 latches rs=0, 8'h01 latches rs=1, and either moves to PAYLOAD. Any other value pulses `frame_err` and returns to HUNT.
  - PAYLOAD: latches the payload. Without the checksum feature, the frame pushes and returns to HUNT.
  - CHECK: present only with the checksum feature; see Configuration.
- A `SYNC_BYTE` value received in TYPE is treated as a bad type. No resync shortcut exists.
- Timeout:
  - `TIMEOUT_CYCLES` = 40*FREQ/BAUD_RATE, i.e. 4 byte times (100_000 at defaults). Counter width is `$clog2(TIMEOUT_CYCLES)`.
  - The counter clears on every `rx_valid` and counts in TYPE, PAYLOAD and CHECK.
  - When it reaches `TIMEOUT_CYCLES`-1: pulse `frame_err`, return to HUNT.
  - The counter is held at 0 in HUNT.
- Push: writes {rs, payload}.
  - If the FIFO is full and no pop occurs in the same cycle, the frame is dropped and `overflow` pulses.
  - A push while full with a simultaneous pop succeeds; level is unchanged.
- Pop: occurs on `lcd_valid` && `lcd_ready`.
- `lcd_valid`, `lcd_rs` and `lcd_data` come straight from registers and the head entry. They stay stable while `lcd_valid`=1 and `lcd_ready`=0.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_level` ranges 0..`FIFO_DEPTH`.
- `err_count` increments by 1 per cycle in which `frame_err` or `overflow` is high (at most one per cycle) and saturates at 255.

## Timing
- Reset values: state HUNT, FIFO empty, `lcd_valid`=0, `lcd_rs`=0, `lcd_data`=0, `fifo_level`=0, `frame_err`=0, `overflow`=0, `err_count`=0, timeout counter=0.
- Reset mid-frame or with the FIFO non-empty discards everything. No write is emitted after reset.
- Latency: the final frame-byte `rx_valid` at cycle N gives `lcd_valid`=1 at cycle N+1 when the FIFO was empty.
- `frame_err`/`overflow` are registered and high in cycle N+1 for a byte at cycle N.
- Sustained pop throughput: one write per cycle.

## Configuration
- Macro: `LCD_SEQ_CHECKSUM_EN`.
- Defined:
  - PAYLOAD moves to CHECK.
  - In CHECK, a byte equal to type XOR payload pushes; any other value pulses `frame_err`. Both return to HUNT.
  - Frames are 4 bytes.
- Undefined: CHECK state and its comparison logic are absent, and frames are 3 bytes.

## Structure
- Package `lcd_seq_pkg` holds:
  - type codes `TYPE_CMD`=8'h00 and `TYPE_DATA`=8'h01;
  - the parser state enum;
  - the `SYNC_BYTE` default;
  - the timeout-multiplier constant (40).
- Sub-module `lcd_cmd_fifo`: a synchronous 9-bit-wide FIFO with push/pop/full/empty/level.
- The parser, timeout and error counter stay in `lcd_rx_sequencer`.

## Test plan
- Bytes A5,00,38 with `lcd_ready`=1 → one transfer with rs=0, data=38; `err_count` stays 0.
- Bytes A5,01,41 and A5,01,42 with `lcd_ready`=0 → `fifo_level`=2 and head 1/41. Then raise `lcd_ready` → 41 then 42 on consecutive cycles.
- Bytes 7E,A5,05 → 7E ignored; `frame_err` pulses once; `err_count`=1; no push.
- Bytes A5,01 then idle for 100_000 cycles → `frame_err` at the timeout; the next A5,00,01 is accepted normally.
- With `lcd_ready`=0, send 5 valid frames at FIFO_DEPTH=4 → `fifo_level`=4 and `overflow` pulses once. Then push on a full FIFO in the same cycle as a pop → accepted, level stays 4.
- With `LCD_SEQ_CHECKSUM_EN`: A5,01,41,40 → pushed. A5,01,41,41 → `frame_err`, no push.
- Extra: reset asserted mid-frame → all outputs return to reset values.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared constants and parser state encoding for lcd_rx_sequencer.
// The CHECK state exists only when LCD_SEQ_CHECKSUM_EN is defined.
package lcd_seq_pkg;

  localparam logic [7:0] TYPE_CMD          = 8'h00;
  localparam logic [7:0] TYPE_DATA         = 8'h01;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  // Inter-byte timeout in bit times: 4 bytes of 10 bits each
  localparam int         TIMEOUT_MULT      = 40;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TYPE,
    ST_PAYLOAD
`ifdef LCD_SEQ_CHECKSUM_EN
    , ST_CHECK
`endif
  } parser_state_t;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of {rs, data} LCD writes; DEPTH must be a power of two.
// A push while full succeeds only when a pop happens in the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_rx_sequencer.sv
// UART byte-stream frame parser feeding a small LCD write FIFO.
// Define LCD_SEQ_CHECKSUM_EN for 4-byte frames with a type^payload check byte.
module lcd_rx_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int         FREQ       = 24_000_000,
  parameter int         BAUD_RATE  = 9600,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_byte,
  output logic                          lcd_valid,
  input  logic                          lcd_ready,
  output logic                          lcd_rs,
  output logic [7:0]                    lcd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [7:0]                    err_count
);

  localparam int             TIMEOUT_CYCLES = TIMEOUT_MULT * FREQ / BAUD_RATE;
  localparam int             TW             = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]  TLIM           = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  parser_state_t state, state_nxt;
  logic [TW-1:0] tcnt;
  logic          rs_q;
`ifdef LCD_SEQ_CHECKSUM_EN
  logic [7:0]    payload_q;
`endif
  logic          timeout;
  logic          push_req;
  logic [8:0]    push_data;
  logic          err_evt;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [8:0]    head;

  // A byte arriving in the expiry cycle wins over the timeout
  assign timeout = (state != ST_HUNT) && !rx_valid && (tcnt == TLIM);
  assign pop     = lcd_valid && lcd_ready;

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_data = {rs_q, rx_byte};
    err_evt   = 1'b0;
    if (timeout) begin
      state_nxt = ST_HUNT;
      err_evt   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        ST_HUNT: begin
          if (rx_byte == SYNC_BYTE) state_nxt = ST_TYPE;
        end
        ST_TYPE: begin
          if (rx_byte == TYPE_CMD || rx_byte == TYPE_DATA) begin
            state_nxt = ST_PAYLOAD;
          end else begin
            state_nxt = ST_HUNT;
            err_evt   = 1'b1;
          end
        end
        ST_PAYLOAD: begin
`ifdef LCD_SEQ_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_HUNT;
          push_req  = 1'b1;
`endif
        end
`ifdef LCD_SEQ_CHECKSUM_EN
        ST_CHECK: begin
          state_nxt = ST_HUNT;
          push_data = {rs_q, payload_q};
          if (rx_byte == (payload_q ^ {7'b0, rs_q})) push_req = 1'b1;
          else                                       err_evt  = 1'b1;
        end
`endif
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_HUNT;
      tcnt      <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      tcnt      <= (rx_valid || timeout || state == ST_HUNT) ? '0 : tcnt + 1'b1;
      frame_err <= err_evt;
      overflow  <= push_req && fifo_full && !pop;
      if (frame_err || overflow) err_count <= sat_inc8(err_count);
    end
  end

  // Frame fields are plain data and need no reset
  always_ff @(posedge clk) begin
    if (rx_valid && state == ST_TYPE) rs_q <= rx_byte[0];
`ifdef LCD_SEQ_CHECKSUM_EN
    if (rx_valid && state == ST_PAYLOAD) payload_q <= rx_byte;
`endif
  end

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign lcd_valid = !fifo_empty;
  assign lcd_rs    = lcd_valid && head[8];
  assign lcd_data  = lcd_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_lcd_rx_sequencer.sv
// Bench for lcd_rx_sequencer: frame-level reference model plus directed frames.
// Honours LCD_SEQ_CHECKSUM_EN for the 4-byte frame format.
module tb_lcd_rx_sequencer;

  localparam int FREQ  = 96_000;
  localparam int BAUD  = 9600;
  localparam int DEPTH = 4;
  localparam int T     = 40 * FREQ / BAUD;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          lcd_ready = 1'b0;
  logic          lcd_valid;
  logic          lcd_rs;
  logic [7:0]    lcd_data;
  logic [LW-1:0] fifo_level;
  logic          frame_err;
  logic          overflow;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  lcd_rx_sequencer #(
    .FREQ       (FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .lcd_valid  (lcd_valid),
    .lcd_ready  (lcd_ready),
    .lcd_rs     (lcd_rs),
    .lcd_data   (lcd_data),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .err_count  (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within frame, idle time, FIFO as a queue
  int         pos = 0;
  int         idle = 0;
  int         m_cnt = 0;
  logic       m_rs = 1'b0;
  logic [7:0] m_pay = 8'h00;
  bit         m_ferr = 1'b0;
  bit         m_ovf = 1'b0;
  logic [8:0] q[$];

  always @(posedge clk) begin : model
    bit         err;
    bit         push;
    logic [8:0] pd;
    if (reset) begin
      pos = 0; idle = 0; m_cnt = 0; m_ferr = 0; m_ovf = 0;
      q.delete();
    end else begin
      err = 0; push = 0; pd = '0;
      if ((m_ferr || m_ovf) && m_cnt < 255) m_cnt++;
      if (rx_valid) begin
        idle = 0;
        case (pos)
          0: if (rx_byte == 8'hA5) pos = 1;
          1: begin
            if (rx_byte == 8'h00 || rx_byte == 8'h01) begin
              m_rs = rx_byte[0]; pos = 2;
            end else begin
              err = 1; pos = 0;
            end
          end
          2: begin
            m_pay = rx_byte;
`ifdef LCD_SEQ_CHECKSUM_EN
            pos = 3;
`else
            push = 1; pd = {m_rs, rx_byte}; pos = 0;
`endif
          end
          3: begin
            if (rx_byte == (m_pay ^ {7'b0, m_rs})) begin
              push = 1; pd = {m_rs, m_pay};
            end else begin
              err = 1;
            end
            pos = 0;
          end
          default: pos = 0;
        endcase
      end else if (pos != 0) begin
        idle++;
        if (idle == T) begin
          err = 1; pos = 0; idle = 0;
        end
      end
      m_ovf = push && (q.size() == DEPTH) && !lcd_ready;
      if (lcd_ready && q.size() > 0) void'(q.pop_front());
      if (push && !m_ovf) q.push_back(pd);
      m_ferr = err;
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] h;
    h = (q.size() > 0) ? q[0] : 9'h000;
    chk("lcd_valid", lcd_valid, q.size() > 0);
    chk("lcd_rs", lcd_rs, h[8]);
    chk("lcd_data", lcd_data, h[7:0]);
    chk("fifo_level", fifo_level, q.size());
    chk("frame_err", frame_err, m_ferr);
    chk("overflow", overflow, m_ovf);
    chk("err_count", err_count, m_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] p, input logic pop_last);
    logic [7:0] last;
    send_byte(8'hA5);
    send_byte(t);
`ifdef LCD_SEQ_CHECKSUM_EN
    send_byte(p);
    last = p ^ t;
`else
    last = p;
`endif
    lcd_ready = pop_last;
    send_byte(last);
    lcd_ready = 1'b0;
  endtask

  int         pulses;
  int         rdy_tab[8] = '{0, 90, 30, 100, 10, 60, 0, 50};
  logic [7:0] b1 = 8'h00;
  logic [7:0] b2 = 8'h00;
  logic [7:0] bsel;

  initial begin
    repeat (3) tick();
    chk("rst_valid", lcd_valid, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_errcnt", err_count, 0);
    reset = 1'b0;

    // Single command write, then drain
    send_frame(8'h00, 8'h38, 1'b0);
    chk("t1_valid", lcd_valid, 1'b1);
    chk("t1_rs", lcd_rs, 1'b0);
    chk("t1_data", lcd_data, 8'h38);
    lcd_ready = 1'b1; tick(); lcd_ready = 1'b0;
    chk("t1_level", fifo_level, 0);
    chk("t1_errcnt", err_count, 0);

    // Two buffered data writes drained on consecutive cycles
    send_frame(8'h01, 8'h41, 1'b0);
    send_frame(8'h01, 8'h42, 1'b0);
    chk("t2_level", fifo_level, 2);
    chk("t2_head_rs", lcd_rs, 1'b1);
    chk("t2_head", lcd_data, 8'h41);
    lcd_ready = 1'b1; tick();
    chk("t2_second", lcd_data, 8'h42);
    tick(); lcd_ready = 1'b0;
    chk("t2_empty", lcd_valid, 1'b0);

    // Noise, then bad type
    send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h05);
    chk("t3_ferr", frame_err, 1'b1);
    tick();
    chk("t3_errcnt", err_count, 1);
    chk("t3_level", fifo_level, 0);

    // Stall mid-frame until timeout, then a clean frame
    send_byte(8'hA5); send_byte(8'h01);
    pulses = 0;
    repeat (T + 10) begin tick(); if (frame_err) pulses++; end
    chk("t4_timeout_pulses", pulses, 1);
    chk("t4_errcnt", err_count, 2);
    send_frame(8'h00, 8'h01, 1'b0);
    chk("t4_data", lcd_data, 8'h01);
    lcd_ready = 1'b1; tick(); lcd_ready = 1'b0;

    // Fill to full, overflow, then push with simultaneous pop
    for (int i = 0; i < 5; i++) send_frame(8'h01, 8'h10 + 8'(i), 1'b0);
    chk("t5_ovf", overflow, 1'b1);
    chk("t5_level", fifo_level, 4);
    tick();
    chk("t5_errcnt", err_count, 3);
    send_frame(8'h01, 8'h15, 1'b1);
    chk("t5_level_keep", fifo_level, 4);
    chk("t5_no_ovf", overflow, 1'b0);
    chk("t5_head", lcd_data, 8'h11);
    lcd_ready = 1'b1; repeat (4) tick(); lcd_ready = 1'b0;
    chk("t5_drained", fifo_level, 0);

`ifdef LCD_SEQ_CHECKSUM_EN
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h41); send_byte(8'h40);
    chk("cs_good_data", lcd_data, 8'h41);
    chk("cs_good_level", fifo_level, 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h41); send_byte(8'h41);
    chk("cs_bad_ferr", frame_err, 1'b1);
    chk("cs_bad_level", fifo_level, 1);
    lcd_ready = 1'b1; tick(); lcd_ready = 1'b0;
`endif

    // Randomised byte stream with varying back-pressure
    for (int blk = 0; blk < 8; blk++) begin
      for (int c = 0; c < 500; c++) begin
        case ($urandom % 10)
          0, 1, 2: bsel = 8'hA5;
          3, 4:    bsel = 8'h00;
          5, 6:    bsel = 8'h01;
          7:       bsel = b1 ^ {7'b0, b2[0]};
          default: bsel = 8'($urandom);
        endcase
        rx_valid  = (($urandom % 3) == 0);
        rx_byte   = bsel;
        lcd_ready = (($urandom % 100) < rdy_tab[blk]);
        if (rx_valid) begin b2 = b1; b1 = bsel; end
        tick();
      end
      rx_valid = 1'b0;
      if (blk % 3 == 1) repeat (T + 5) tick();
    end
    lcd_ready = 1'b0;

    // Reset mid-frame with a non-empty FIFO
    send_frame(8'h00, 8'h55, 1'b0);
    send_byte(8'hA5); send_byte(8'h01);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    chk("rst2_valid", lcd_valid, 1'b0);
    chk("rst2_data", lcd_data, 8'h00);
    chk("rst2_rs", lcd_rs, 1'b0);
    chk("rst2_level", fifo_level, 0);
    chk("rst2_errcnt", err_count, 0);
    chk("rst2_ferr", frame_err, 1'b0);
    send_byte(8'h41);
    tick();
    chk("rst2_no_push", fifo_level, 0);
    chk("rst2_no_err", frame_err, 1'b0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
